// File: rtl/fifo_wr_cntrl_pkg.sv
// Shared FIFO definitions: default address width and Gray/binary pointer conversions.
// Conversions work on 32-bit vectors; callers zero-extend and keep the low pointer bits.
package fifo_wr_cntrl_pkg;

  localparam int FIFO_ADDRESS_WIDTH = 3;
  localparam int FIFO_CONV_W        = 32;

  function automatic logic [FIFO_CONV_W-1:0] bin2gray(input logic [FIFO_CONV_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [FIFO_CONV_W-1:0] gray2bin(input logic [FIFO_CONV_W-1:0] gray);
    logic [FIFO_CONV_W-1:0] bin;
    bin[FIFO_CONV_W-1] = gray[FIFO_CONV_W-1];
    for (int i = FIFO_CONV_W-2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wr_cntrl_sync.sv
// Two-stage synchronizer bringing a Gray pointer into the wclk domain.
module fifo_ptr_sync #(
  parameter int WIDTH = 4
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_stage1;
  logic [WIDTH-1:0] r_stage2;

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      r_stage1 <= '0;
      r_stage2 <= '0;
    end else begin
      r_stage1 <= i_async;
      r_stage2 <= r_stage1;
    end
  end

  assign o_sync = r_stage2;

endmodule

// File: rtl/fifo_wr_cntrl.sv
// Write-side FIFO controller: binary/Gray write pointer, full, level, almost-full
// and sticky overflow, all computed against the synchronized read pointer.
module fifo_wr_cntrl
  import fifo_wr_cntrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = FIFO_ADDRESS_WIDTH,
  parameter int AFULL_THRESH  = 6
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic                     winc,
  input  logic [ADDRESS_WIDTH:0]   rptr_gray,
  input  logic                     woverflow_clr,
  output logic                     wclken,
  output logic [ADDRESS_WIDTH-1:0] waddr,
  output logic [ADDRESS_WIDTH:0]   wptr_gray,
  output logic                     wfull,
  output logic                     walmost_full,
  output logic [ADDRESS_WIDTH:0]   wlevel,
  output logic                     woverflow
);

  localparam int PW = ADDRESS_WIDTH + 1;
  localparam logic [ADDRESS_WIDTH:0] AFULL_L = PW'(AFULL_THRESH);

  logic [ADDRESS_WIDTH:0]   r_wbin;
  logic [ADDRESS_WIDTH:0]   r_wgray;
  logic                     r_wfull;
  logic                     r_walmost_full;
  logic [ADDRESS_WIDTH:0]   r_wlevel;
  logic                     r_woverflow;

  logic [ADDRESS_WIDTH:0]   w_rq2;
  logic [ADDRESS_WIDTH:0]   w_wbin_next;
  logic [ADDRESS_WIDTH:0]   w_wgray_next;
  logic [ADDRESS_WIDTH:0]   w_rbin;
  logic [ADDRESS_WIDTH:0]   w_level_next;
  logic [ADDRESS_WIDTH:0]   w_full_cmp;
  logic                     w_full_next;
  logic                     w_wclken;
  logic                     w_ovf_set;
  logic [FIFO_CONV_W-1:0]   w_gray32;
  logic [FIFO_CONV_W-1:0]   w_rbin32;
  logic                     w_unused;

  fifo_ptr_sync #(.WIDTH(PW)) u_rptr_sync (
    .wclk    (wclk),
    .wrst    (wrst),
    .i_async (rptr_gray),
    .o_sync  (w_rq2)
  );

  // Gating with wrst keeps the memory write strobe quiet while reset is held.
  assign w_wclken     = winc & ~r_wfull & wrst;
  assign w_wbin_next  = r_wbin + {{ADDRESS_WIDTH{1'b0}}, w_wclken};
  assign w_gray32     = bin2gray(FIFO_CONV_W'(w_wbin_next));
  assign w_wgray_next = w_gray32[ADDRESS_WIDTH:0];
  assign w_rbin32     = gray2bin(FIFO_CONV_W'(w_rq2));
  assign w_rbin       = w_rbin32[ADDRESS_WIDTH:0];
  assign w_level_next = w_wbin_next - w_rbin;
  // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
  assign w_full_cmp   = {~w_rq2[ADDRESS_WIDTH:ADDRESS_WIDTH-1], w_rq2[ADDRESS_WIDTH-2:0]};
  assign w_full_next  = (w_wgray_next == w_full_cmp);
  assign w_ovf_set    = winc & r_wfull;
  assign w_unused     = ^{w_gray32[FIFO_CONV_W-1:PW], w_rbin32[FIFO_CONV_W-1:PW]};

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      r_wbin         <= '0;
      r_wgray        <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wlevel       <= '0;
    end else begin
      r_wbin         <= w_wbin_next;
      r_wgray        <= w_wgray_next;
      r_wfull        <= w_full_next;
      r_walmost_full <= (w_level_next >= AFULL_L);
      r_wlevel       <= w_level_next;
    end
  end

  // Set has priority over clear so a same-edge overflow is never lost.
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      r_woverflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_woverflow <= 1'b1;
    end else if (woverflow_clr) begin
      r_woverflow <= 1'b0;
    end
  end

  assign wclken       = w_wclken;
  assign waddr        = r_wbin[ADDRESS_WIDTH-1:0];
  assign wptr_gray    = r_wgray;
  assign wfull        = r_wfull;
  assign walmost_full = r_walmost_full;
  assign wlevel       = r_wlevel;
  assign woverflow    = r_woverflow;

endmodule
